// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a single-layer CNN engine through NUM_LAYER table-configured layers.
// Optional per-layer watchdog with an ERROR state is enabled by defining LAYER_TIMEOUT_EN.
module layer_sequencer #(
  parameter int          NUM_LAYER      = 7,
  parameter int          CFG_WIDTH      = 34,
  parameter int          OFM_BASE_ODD   = 526656,
  parameter int          ADDR_WIDTH     = 22,
  parameter int unsigned TIMEOUT_CYCLES = 67108864,
  localparam int         LW             = (NUM_LAYER > 1) ? $clog2(NUM_LAYER) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_CNN,
  input  logic                  cfg_we,
  input  logic [LW-1:0]         cfg_layer,
  input  logic [CFG_WIDTH-1:0]  cfg_data,
  input  logic                  layer_done,
  output logic                  start_layer,
  output logic [LW-1:0]         count_layer,
  output logic [CFG_WIDTH-1:0]  layer_cfg,
  output logic [ADDR_WIDTH-1:0] ofm_base,
  output logic                  busy,
  output logic                  done_CNN,
  output logic                  err_timeout
);

  localparam logic [LW-1:0]         LAST_LAYER = LW'(NUM_LAYER - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_ODD   = ADDR_WIDTH'(OFM_BASE_ODD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_NEXT  = 3'd4,
`ifdef LAYER_TIMEOUT_EN
    S_DONE  = 3'd5,
    S_ERROR = 3'd6
`else
    S_DONE  = 3'd5
`endif
  } state_t;

  state_t               state;
  logic [CFG_WIDTH-1:0] cfg_table [NUM_LAYER];
  logic                 cfg_wr_en;

  // Table is frozen while a run is active so every layer sees the config captured at start.
  assign cfg_wr_en = cfg_we && !busy && (cfg_layer <= LAST_LAYER);

`ifdef LAYER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer;
`else
  assign err_timeout = 1'b0;
`endif

  // Layer configuration table
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LAYER; i++) begin
        cfg_table[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      cfg_table[cfg_layer] <= cfg_data;
    end
  end

  // Sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      start_layer <= 1'b0;
      done_CNN    <= 1'b0;
      busy        <= 1'b0;
      count_layer <= '0;
      layer_cfg   <= '0;
      ofm_base    <= '0;
`ifdef LAYER_TIMEOUT_EN
      err_timeout <= 1'b0;
      timer       <= '0;
`endif
    end else begin
      start_layer <= 1'b0;
      done_CNN    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_CNN) begin
            state       <= S_LOAD;
            count_layer <= '0;
            busy        <= 1'b1;
          end
        end
        S_LOAD: begin
          layer_cfg   <= cfg_table[count_layer];
          ofm_base    <= count_layer[0] ? BASE_ODD : '0;
          start_layer <= 1'b1;
          state       <= S_START;
        end
        S_START: begin
          state <= S_WAIT;
`ifdef LAYER_TIMEOUT_EN
          timer <= '0;
`endif
        end
        S_WAIT: begin
          if (layer_done) begin
            state <= S_NEXT;
`ifdef LAYER_TIMEOUT_EN
          end else if (timer == TIMER_LAST) begin
            state       <= S_ERROR;
            err_timeout <= 1'b1;
            busy        <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
`endif
          end
        end
        S_NEXT: begin
          if (count_layer == LAST_LAYER) begin
            state    <= S_DONE;
            done_CNN <= 1'b1;
            busy     <= 1'b0;
          end else begin
            count_layer <= count_layer + LW'(1);
            state       <= S_LOAD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
`ifdef LAYER_TIMEOUT_EN
        S_ERROR: begin
          if (start_CNN) begin
            state       <= S_IDLE;
            err_timeout <= 1'b0;
          end
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
